// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// registers {PC, instruction, valid} into IF/ID; handles redirect, stall, halt and flush.
module if_fetch_stage #(
   parameter int unsigned PC_W  = 9,
   parameter int unsigned INS_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             PcSel,
   input  logic [31:0]      BrPC,
   input  logic             Halt,
   input  logic             Stall,
   input  logic [INS_W-1:0] Instr,
   output logic [PC_W-1:0]  ImemAddr,
   output logic [PC_W-1:0]  IF_PC,
   output logic [INS_W-1:0] IF_Instr,
   output logic             IF_Valid,
   output logic             Flush,
   output logic             Halted
);

   localparam int unsigned BR_W = 32;

   typedef enum logic [1:0] {
      S_BOOT   = 2'd0,
      S_RUN    = 2'd1,
      S_HALTED = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [PC_W-1:0]    if_pc_q, if_pc_d;
   logic [INS_W-1:0]   if_instr_q, if_instr_d;
   logic               if_valid_q, if_valid_d;
   logic               flush_c;
   logic [PC_W-1:0]    pc_inc;
   logic [PC_W-1:0]    redir_pc;
   logic               unused_brpc;

   // Upper target bits are dropped and the low two are forced to word alignment.
   assign redir_pc    = BrPC[PC_W-1:0] & ~PC_W'(3);
   assign pc_inc      = pc_q + PC_W'(4);
   assign unused_brpc = ^BrPC[BR_W-1:PC_W];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_BOOT:   state_d = S_RUN;
         S_RUN:    if (PcSel && Halt) state_d = S_HALTED;
         S_HALTED: state_d = S_HALTED;
         default:  state_d = S_BOOT;
      endcase
   end

   // Datapath next values and flush; redirect has priority over stall in RUN.
   always_comb begin
      pc_d       = pc_q;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      if_valid_d = if_valid_q;
      flush_c    = 1'b0;
      case (state_q)
         S_BOOT: begin
            if_pc_d    = '0;
            if_instr_d = Instr;
            if_valid_d = 1'b1;
            pc_d       = pc_inc;
         end
         S_RUN: begin
            flush_c = PcSel;
            if (PcSel) begin
               pc_d       = redir_pc;
               if_instr_d = '0;
               if_valid_d = 1'b0;
            end else if (!Stall) begin
               if_pc_d    = pc_q;
               if_instr_d = Instr;
               if_valid_d = 1'b1;
               pc_d       = pc_inc;
            end
         end
         S_HALTED: begin
            if_instr_d = '0;
            if_valid_d = 1'b0;
         end
         default: begin
            pc_d = pc_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q       <= '0;
         if_pc_q    <= '0;
         if_instr_q <= '0;
         if_valid_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
         if_valid_q <= if_valid_d;
      end
   end

   assign ImemAddr = pc_q;
   assign IF_PC    = if_pc_q;
   assign IF_Instr = if_instr_q;
   assign IF_Valid = if_valid_q;
   assign Flush    = flush_c;
   assign Halted   = (state_q == S_HALTED);

endmodule
